// File: rtl/unsigned_mul_8x8_ha_array_reducer_pkg.sv
// Shared types and widths for the approximate 8x8 multiplier half-adder-array path.
// Each group carries a 9-bit sum row (t) and a 7-bit carry row (b) two bit positions above it.
package unsigned_mul_8x8_pkg;

   localparam int HA_B_W    = 7;
   localparam int HA_T_W    = 9;
   localparam int HA_GROUPS = 4;
   localparam int PROD_W    = 16;
   localparam int SUM_W     = 17;
   localparam int G_W       = 11;
   localparam int S1_W      = 13;

   typedef struct packed {
      logic [HA_B_W-1:0] b;
      logic [HA_T_W-1:0] t;
   } ha_group_t;

   // The carry row sits two bit positions above the sum row.
   function automatic logic [G_W-1:0] group_value(ha_group_t grp);
      return {2'b00, grp.t} + {2'b00, grp.b, 2'b00};
   endfunction

endpackage

// File: rtl/unsigned_mul_8x8_ha_array_reducer_if.sv
// Handshake bus between the half-adder-array generator, the reducer and the product consumer.
// The master side drives groups and out_ready; the slave side is the reducer.
interface unsigned_mul_8x8_ha_array_reducer_if #(
   parameter int SAT_CNT_W = 8
) ();
   import unsigned_mul_8x8_pkg::*;

   logic                 in_valid;
   logic                 in_ready;
   logic [HA_B_W-1:0]    ha_array_0_b;
   logic [HA_B_W-1:0]    ha_array_1_b;
   logic [HA_B_W-1:0]    ha_array_2_b;
   logic [HA_B_W-1:0]    ha_array_3_b;
   logic [HA_T_W-1:0]    ha_array_0_t;
   logic [HA_T_W-1:0]    ha_array_1_t;
   logic [HA_T_W-1:0]    ha_array_2_t;
   logic [HA_T_W-1:0]    ha_array_3_t;
   logic                 out_valid;
   logic                 out_ready;
   logic [PROD_W-1:0]    product;
   logic                 sat;
   logic [SAT_CNT_W-1:0] sat_count;

   modport master (
      output in_valid, ha_array_0_b, ha_array_1_b, ha_array_2_b, ha_array_3_b,
             ha_array_0_t, ha_array_1_t, ha_array_2_t, ha_array_3_t, out_ready,
      input  in_ready, out_valid, product, sat, sat_count
   );

   modport slave (
      input  in_valid, ha_array_0_b, ha_array_1_b, ha_array_2_b, ha_array_3_b,
             ha_array_0_t, ha_array_1_t, ha_array_2_t, ha_array_3_t, out_ready,
      output in_ready, out_valid, product, sat, sat_count
   );

endinterface

// File: rtl/unsigned_mul_8x8_ha_array_reducer_ha_group_weigh.sv
// Combinational weighting of one half-adder-array group into its 11-bit value.
module ha_group_weigh
   import unsigned_mul_8x8_pkg::*;
(
   input  ha_group_t      grp,
   output logic [G_W-1:0] g_val
);

   assign g_val = group_value(grp);

endmodule

// File: rtl/unsigned_mul_8x8_ha_array_reducer.sv
// Two-stage elastic reducer: weighs and pairs the four groups, then sums and saturates to 16 bits.
// Counts delivered saturated products in a sticky counter.
module unsigned_mul_8x8_ha_array_reducer #(
   parameter int SAT_CNT_W = 8
) (
   input logic                            clk,
   input logic                            rst,
   unsigned_mul_8x8_ha_array_reducer_if.slave bus
);
   import unsigned_mul_8x8_pkg::*;

   ha_group_t            grp [HA_GROUPS];
   logic [G_W-1:0]       g_val [HA_GROUPS];

   logic                 v1_reg;
   logic                 v2_reg;
   logic                 adv1;
   logic                 adv2;
   logic [S1_W-1:0]      s01_reg;
   logic [S1_W-1:0]      s23_reg;
   logic [S1_W-1:0]      s01_next;
   logic [S1_W-1:0]      s23_next;
   logic [SUM_W-1:0]     sum_next;
   logic [PROD_W-1:0]    product_next;
   logic                 sat_next;
   logic [PROD_W-1:0]    product_reg;
   logic                 sat_reg;
   logic [SAT_CNT_W-1:0] sat_count_reg;
   logic                 out_fire;

   assign grp[0] = {bus.ha_array_0_b, bus.ha_array_0_t};
   assign grp[1] = {bus.ha_array_1_b, bus.ha_array_1_t};
   assign grp[2] = {bus.ha_array_2_b, bus.ha_array_2_t};
   assign grp[3] = {bus.ha_array_3_b, bus.ha_array_3_t};

   generate
      for (genvar gi = 0; gi < HA_GROUPS; gi++) begin : g_weigh
         ha_group_weigh u_weigh (
            .grp   (grp[gi]),
            .g_val (g_val[gi])
         );
      end
   endgenerate

   // Odd groups sit two bit positions above their even partner.
   assign s01_next = {2'b00, g_val[0]} + {g_val[1], 2'b00};
   assign s23_next = {2'b00, g_val[2]} + {g_val[3], 2'b00};

   // The sum never reaches 2^17, so bit 16 alone flags overflow of the 16-bit product.
   assign sum_next     = {4'b0000, s01_reg} + {s23_reg, 4'b0000};
   assign sat_next     = sum_next[SUM_W-1];
   assign product_next = sat_next ? {PROD_W{1'b1}} : sum_next[PROD_W-1:0];

   assign adv2     = !v2_reg || bus.out_ready;
   assign adv1     = !v1_reg || adv2;
   assign out_fire = v2_reg && bus.out_ready;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         v1_reg        <= 1'b0;
         v2_reg        <= 1'b0;
         s01_reg       <= '0;
         s23_reg       <= '0;
         product_reg   <= '0;
         sat_reg       <= 1'b0;
         sat_count_reg <= '0;
      end else begin
         if (adv1) begin
            v1_reg <= bus.in_valid;
            if (bus.in_valid) begin
               s01_reg <= s01_next;
               s23_reg <= s23_next;
            end
         end
         if (adv2) begin
            v2_reg <= v1_reg;
            if (v1_reg) begin
               product_reg <= product_next;
               sat_reg     <= sat_next;
            end
         end
         if (out_fire && sat_reg && (sat_count_reg != {SAT_CNT_W{1'b1}})) begin
            sat_count_reg <= sat_count_reg + SAT_CNT_W'(1);
         end
      end
   end

   assign bus.in_ready  = adv1;
   assign bus.out_valid = v2_reg;
   assign bus.product   = product_reg;
   assign bus.sat       = sat_reg;
   assign bus.sat_count = sat_count_reg;

endmodule

// File: tb/tb_unsigned_mul_8x8_ha_array_reducer.sv
// Directed bench for the half-adder-array reducer: weights, saturation, back-pressure,
// mid-flight reset and a narrow sticky saturation counter on a second instance.
module tb_unsigned_mul_8x8_ha_array_reducer;
   import unsigned_mul_8x8_pkg::*;

   logic clk = 1'b0;
   logic rst;

   unsigned_mul_8x8_ha_array_reducer_if #(.SAT_CNT_W(8)) bus ();
   unsigned_mul_8x8_ha_array_reducer_if #(.SAT_CNT_W(2)) bus2 ();

   unsigned_mul_8x8_ha_array_reducer #(.SAT_CNT_W(8)) u_dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   unsigned_mul_8x8_ha_array_reducer #(.SAT_CNT_W(2)) u_dut_narrow (
      .clk (clk),
      .rst (rst),
      .bus (bus2)
   );

   always #5 clk = ~clk;

   int         vectors     = 0;
   int         miscompares = 0;
   logic [7:0] exp_cnt     = '0;

   task automatic drive(input logic [3:0][6:0] b, input logic [3:0][8:0] t, input logic v);
      bus.ha_array_0_b = b[0];
      bus.ha_array_1_b = b[1];
      bus.ha_array_2_b = b[2];
      bus.ha_array_3_b = b[3];
      bus.ha_array_0_t = t[0];
      bus.ha_array_1_t = t[1];
      bus.ha_array_2_t = t[2];
      bus.ha_array_3_t = t[3];
      bus.in_valid     = v;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      bus.out_ready = 1'b0;
      drive('0, '0, 1'b0);
      @(posedge clk);
      @(posedge clk);
      #1;
      vectors++;
      if (bus.out_valid !== 1'b0 || bus.product !== 16'h0000 || bus.sat !== 1'b0) begin
         miscompares++;
         $display("FAIL reset_outputs: valid=%b product=%h sat=%b, expected 0/0000/0",
                  bus.out_valid, bus.product, bus.sat);
      end
      vectors++;
      if (bus.sat_count !== 8'd0 || bus.in_ready !== 1'b1) begin
         miscompares++;
         $display("FAIL reset_count_ready: sat_count=%0d in_ready=%b, expected 0/1",
                  bus.sat_count, bus.in_ready);
      end
      #2 rst = 1'b0;
      @(posedge clk);
      #1;
      vectors++;
      if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0) begin
         miscompares++;
         $display("FAIL post_reset: in_ready=%b out_valid=%b, expected 1/0",
                  bus.in_ready, bus.out_valid);
      end
      $display("reset: done");
   endtask

   task automatic test_zero();
      bus.out_ready = 1'b1;
      drive('0, '0, 1'b1);
      #1;
      vectors++;
      if (bus.in_ready !== 1'b1) begin
         miscompares++;
         $display("FAIL zero_in_ready: got %b, expected 1", bus.in_ready);
      end
      @(posedge clk);
      #1;
      drive('0, '0, 1'b0);
      vectors++;
      if (bus.out_valid !== 1'b0) begin
         miscompares++;
         $display("FAIL zero_latency_early: out_valid=%b, expected 0", bus.out_valid);
      end
      @(posedge clk);
      #1;
      vectors++;
      if (bus.out_valid !== 1'b1 || bus.product !== 16'h0000 || bus.sat !== 1'b0) begin
         miscompares++;
         $display("FAIL zero_product: valid=%b product=%h sat=%b, expected 1/0000/0",
                  bus.out_valid, bus.product, bus.sat);
      end
      @(posedge clk);
      #1;
      vectors++;
      if (bus.out_valid !== 1'b0) begin
         miscompares++;
         $display("FAIL zero_drain: out_valid=%b, expected 0", bus.out_valid);
      end
      $display("zero: product=%h sat=%b", bus.product, bus.sat);
   endtask

   task automatic test_weights();
      logic [3:0][6:0] wb [6];
      logic [3:0][8:0] wt [6];
      logic [15:0]     wp [6];
      wb[0] = '0;                          wt[0] = {9'd0, 9'd0, 9'd0, 9'h001};   wp[0] = 16'd1;
      wb[1] = {7'd0, 7'd0, 7'd0, 7'h01};   wt[1] = '0;                           wp[1] = 16'd4;
      wb[2] = '0;                          wt[2] = {9'h100, 9'd0, 9'd0, 9'd0};   wp[2] = 16'd16384;
      wb[3] = {7'd0, 7'h40, 7'd0, 7'd0};   wt[3] = '0;                           wp[3] = 16'd4096;
      wb[4] = {7'h7F, 7'd0, 7'd0, 7'd0};   wt[4] = {9'd0, 9'd3, 9'h1FF, 9'd0};   wp[4] = 16'd34604;
      wb[5] = {7'd0, 7'd0, 7'd1, 7'h7F};   wt[5] = {9'd0, 9'd0, 9'd0, 9'h1FF};   wp[5] = 16'd1035;
      bus.out_ready = 1'b1;
      for (int i = 0; i < 6; i++) begin
         drive(wb[i], wt[i], 1'b1);
         @(posedge clk);
         #1;
         drive('0, '0, 1'b0);
         @(posedge clk);
         #1;
         vectors++;
         if (bus.out_valid !== 1'b1 || bus.product !== wp[i] || bus.sat !== 1'b0) begin
            miscompares++;
            $display("FAIL weight_%0d: valid=%b product=%0d sat=%b, expected 1/%0d/0",
                     i, bus.out_valid, bus.product, bus.sat, wp[i]);
         end
         $display("weight_%0d: product=%0d expected=%0d", i, bus.product, wp[i]);
         @(posedge clk);
         #1;
         vectors++;
         if (bus.out_valid !== 1'b0 || bus.sat_count !== exp_cnt) begin
            miscompares++;
            $display("FAIL weight_%0d_after: valid=%b sat_count=%0d, expected 0/%0d",
                     i, bus.out_valid, bus.sat_count, exp_cnt);
         end
      end
   endtask

   task automatic test_saturation();
      logic [3:0][6:0] sb [3];
      logic [3:0][8:0] st [3];
      logic [15:0]     sp [3];
      logic            ss [3];
      sb[0] = {4{7'h7F}};                  st[0] = {4{9'h1FF}};                   sp[0] = 16'hFFFF; ss[0] = 1'b1;
      sb[1] = {7'h7F, 7'd0, 7'd0, 7'd0};   st[1] = {9'h1FF, 9'd0, 9'd0, 9'd319};  sp[1] = 16'hFFFF; ss[1] = 1'b0;
      sb[2] = {7'h7F, 7'd0, 7'd0, 7'd0};   st[2] = {9'h1FF, 9'd0, 9'd0, 9'd320};  sp[2] = 16'hFFFF; ss[2] = 1'b1;
      bus.out_ready = 1'b1;
      for (int i = 0; i < 3; i++) begin
         drive(sb[i], st[i], 1'b1);
         @(posedge clk);
         #1;
         drive('0, '0, 1'b0);
         @(posedge clk);
         #1;
         vectors++;
         if (bus.out_valid !== 1'b1 || bus.product !== sp[i] || bus.sat !== ss[i]) begin
            miscompares++;
            $display("FAIL sat_%0d: valid=%b product=%h sat=%b, expected 1/%h/%b",
                     i, bus.out_valid, bus.product, bus.sat, sp[i], ss[i]);
         end
         vectors++;
         if (bus.sat_count !== exp_cnt) begin
            miscompares++;
            $display("FAIL sat_%0d_pre_count: sat_count=%0d, expected %0d", i, bus.sat_count, exp_cnt);
         end
         if (ss[i]) exp_cnt = exp_cnt + 8'd1;
         @(posedge clk);
         #1;
         vectors++;
         if (bus.sat_count !== exp_cnt) begin
            miscompares++;
            $display("FAIL sat_%0d_post_count: sat_count=%0d, expected %0d", i, bus.sat_count, exp_cnt);
         end
         $display("sat_%0d: product=%h sat=%b sat_count=%0d", i, bus.product, bus.sat, bus.sat_count);
      end
   endtask

   task automatic test_back_to_back();
      logic [15:0]     exp_p [4];
      logic [3:0][8:0] t_vec;
      int              acc = 0;
      int              got = 0;
      logic            in_hs;
      logic            out_hs;
      exp_p[0] = 16'd10;
      exp_p[1] = 16'd20;
      exp_p[2] = 16'd30;
      exp_p[3] = 16'd40;
      for (int c = 0; c < 20 && got < 4; c++) begin
         bus.out_ready = (c >= 3);
         t_vec = '0;
         if (acc < 4) t_vec[0] = exp_p[acc][8:0];
         drive('0, t_vec, acc < 4);
         #1;
         if (c == 2) begin
            vectors++;
            if (bus.in_ready !== 1'b0 || acc != 2) begin
               miscompares++;
               $display("FAIL b2b_stall_ready: in_ready=%b accepted=%0d, expected 0/2", bus.in_ready, acc);
            end
            vectors++;
            if (bus.out_valid !== 1'b1 || bus.product !== exp_p[0]) begin
               miscompares++;
               $display("FAIL b2b_stall_hold: valid=%b product=%0d, expected 1/%0d",
                        bus.out_valid, bus.product, exp_p[0]);
            end
         end
         in_hs  = bus.in_valid && bus.in_ready;
         out_hs = bus.out_valid && bus.out_ready;
         if (out_hs) begin
            vectors++;
            if (bus.product !== exp_p[got]) begin
               miscompares++;
               $display("FAIL b2b_order_%0d: product=%0d, expected %0d", got, bus.product, exp_p[got]);
            end
            $display("b2b_%0d: product=%0d expected=%0d", got, bus.product, exp_p[got]);
            got++;
         end
         @(posedge clk);
         #1;
         if (in_hs) acc++;
      end
      drive('0, '0, 1'b0);
      vectors++;
      if (got != 4) begin
         miscompares++;
         $display("FAIL b2b_count: delivered=%0d, expected 4", got);
      end
   endtask

   task automatic test_reset_midflight();
      logic [3:0][8:0] t_vec;
      logic            seen = 1'b0;
      bus.out_ready = 1'b0;
      t_vec = '0;
      t_vec[0] = 9'd5;
      drive('0, t_vec, 1'b1);
      @(posedge clk);
      #1;
      t_vec[0] = 9'd6;
      drive('0, t_vec, 1'b1);
      @(posedge clk);
      #1;
      drive('0, '0, 1'b0);
      vectors++;
      if (bus.out_valid !== 1'b1 || bus.in_ready !== 1'b0) begin
         miscompares++;
         $display("FAIL midrst_full: valid=%b in_ready=%b, expected 1/0", bus.out_valid, bus.in_ready);
      end
      #2 rst = 1'b1;
      #1;
      vectors++;
      if (bus.out_valid !== 1'b0 || bus.product !== 16'h0000 || bus.sat_count !== 8'd0 || bus.in_ready !== 1'b1) begin
         miscompares++;
         $display("FAIL midrst_clear: valid=%b product=%h sat_count=%0d in_ready=%b, expected 0/0000/0/1",
                  bus.out_valid, bus.product, bus.sat_count, bus.in_ready);
      end
      exp_cnt = '0;
      @(posedge clk);
      #3 rst = 1'b0;
      @(posedge clk);
      #1;
      vectors++;
      if (bus.out_valid !== 1'b0) begin
         miscompares++;
         $display("FAIL midrst_stale: out_valid=%b after release, expected 0", bus.out_valid);
      end
      bus.out_ready = 1'b1;
      t_vec[0] = 9'd77;
      drive('0, t_vec, 1'b1);
      @(posedge clk);
      #1;
      drive('0, '0, 1'b0);
      for (int c = 0; c < 5 && !seen; c++) begin
         if (bus.out_valid === 1'b1) begin
            seen = 1'b1;
            vectors++;
            if (bus.product !== 16'd77) begin
               miscompares++;
               $display("FAIL midrst_first: product=%0d, expected 77", bus.product);
            end
            $display("midrst: first product=%0d expected=77", bus.product);
         end
         @(posedge clk);
         #1;
      end
      vectors++;
      if (!seen) begin
         miscompares++;
         $display("FAIL midrst_timeout: out_valid=0, expected a product within 5 cycles");
      end
   endtask

   task automatic test_counter_saturation();
      int         acc = 0;
      int         n   = 0;
      logic [1:0] exp2;
      logic       in_hs;
      logic       out_hs;
      bus2.out_ready    = 1'b1;
      bus2.ha_array_0_b = 7'h7F;
      bus2.ha_array_1_b = 7'h7F;
      bus2.ha_array_2_b = 7'h7F;
      bus2.ha_array_3_b = 7'h7F;
      bus2.ha_array_0_t = 9'h1FF;
      bus2.ha_array_1_t = 9'h1FF;
      bus2.ha_array_2_t = 9'h1FF;
      bus2.ha_array_3_t = 9'h1FF;
      for (int c = 0; c < 30 && n < 5; c++) begin
         bus2.in_valid = (acc < 5);
         #1;
         in_hs  = bus2.in_valid && bus2.in_ready;
         out_hs = bus2.out_valid && bus2.out_ready;
         if (out_hs) begin
            vectors++;
            if (bus2.product !== 16'hFFFF || bus2.sat !== 1'b1) begin
               miscompares++;
               $display("FAIL cnt_product_%0d: product=%h sat=%b, expected FFFF/1", n, bus2.product, bus2.sat);
            end
         end
         @(posedge clk);
         #1;
         if (in_hs) acc++;
         if (out_hs) begin
            n++;
            exp2 = (n > 3) ? 2'd3 : 2'(n);
            vectors++;
            if (bus2.sat_count !== exp2) begin
               miscompares++;
               $display("FAIL cnt_sticky_%0d: sat_count=%0d, expected %0d", n, bus2.sat_count, exp2);
            end
            $display("cnt_%0d: sat_count=%0d expected=%0d", n, bus2.sat_count, exp2);
         end
      end
      bus2.in_valid = 1'b0;
      vectors++;
      if (n != 5 || bus2.sat_count !== 2'd3) begin
         miscompares++;
         $display("FAIL cnt_final: delivered=%0d sat_count=%0d, expected 5/3", n, bus2.sat_count);
      end
   endtask

   initial begin
      rst = 1'b1;
      bus2.in_valid     = 1'b0;
      bus2.out_ready    = 1'b0;
      bus2.ha_array_0_b = '0;
      bus2.ha_array_1_b = '0;
      bus2.ha_array_2_b = '0;
      bus2.ha_array_3_b = '0;
      bus2.ha_array_0_t = '0;
      bus2.ha_array_1_t = '0;
      bus2.ha_array_2_t = '0;
      bus2.ha_array_3_t = '0;
      test_reset();
      test_zero();
      test_weights();
      test_saturation();
      test_back_to_back();
      test_reset_midflight();
      test_counter_saturation();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
